// File: rtl/mult_div_rs_age.sv
// Age-ordered reservation station for the mult/div unit: in-order-by-age issue,
// CDB/commit wakeup with dispatch-cycle bypass, single issue per cycle.
module mult_div_rs_age #(
    parameter int RS_DEPTH  = 4,
    parameter int ROB_DEPTH = 16,
    parameter int NUM_CDB   = 4,
    parameter int DATA_W    = 32,
    localparam int TAG_W    = $clog2(ROB_DEPTH),
    localparam int IDX_W    = $clog2(RS_DEPTH),
    localparam int CNT_W    = $clog2(RS_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    input  logic [31:0]               disp_instr_i,
    input  logic [TAG_W-1:0]          disp_tag_dest_i,
    input  logic [TAG_W-1:0]          disp_tag_a_i,
    input  logic [TAG_W-1:0]          disp_tag_b_i,
    input  logic [DATA_W-1:0]         disp_data_a_i,
    input  logic [DATA_W-1:0]         disp_data_b_i,
    input  logic                      disp_rdy_a_i,
    input  logic                      disp_rdy_b_i,
    input  logic [NUM_CDB-1:0]        cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
    input  logic                      commit_valid_i,
    input  logic [TAG_W-1:0]          commit_tag_i,
    input  logic [DATA_W-1:0]         commit_data_i,
    output logic                      iss_valid_o,
    input  logic                      iss_ready_i,
    output logic [31:0]               iss_instr_o,
    output logic [TAG_W-1:0]          iss_tag_dest_o,
    output logic [DATA_W-1:0]         iss_data_a_o,
    output logic [DATA_W-1:0]         iss_data_b_o,
    output logic [CNT_W-1:0]          count_o
);

    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [31:0]         instr_q   [RS_DEPTH], instr_d   [RS_DEPTH];
    logic [TAG_W-1:0]    tagDest_q [RS_DEPTH], tagDest_d [RS_DEPTH];
    logic [TAG_W-1:0]    tagA_q    [RS_DEPTH], tagA_d    [RS_DEPTH];
    logic [TAG_W-1:0]    tagB_q    [RS_DEPTH], tagB_d    [RS_DEPTH];
    logic [DATA_W-1:0]   dataA_q   [RS_DEPTH], dataA_d   [RS_DEPTH];
    logic [DATA_W-1:0]   dataB_q   [RS_DEPTH], dataB_d   [RS_DEPTH];
    logic [RS_DEPTH-1:0] rdyA_q, rdyA_d, rdyB_q, rdyB_d;
    // older_q[j][i] set means entry j was dispatched before entry i
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH], older_d [RS_DEPTH];

    logic [RS_DEPTH-1:0] eligible;
    logic [IDX_W-1:0]    selIdx, freeIdx;
    logic                issFound, freeFound, blocked;
    logic                doIssue, doDisp;
    logic [CNT_W-1:0]    occupancy;
    logic [DATA_W:0]     hitA, hitB;

    // Lowest CDB port wins, and any CDB hit overrides the commit forward
    function automatic logic [DATA_W:0] cdbLookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        if (commit_valid_i && commit_tag_i == tag)
            res = {1'b1, commit_data_i};
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cdb_valid_i[p] && cdb_tag_i[p*TAG_W +: TAG_W] == tag)
                res = {1'b1, cdb_data_i[p*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    always_comb begin
        occupancy = '0;
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            occupancy = occupancy + CNT_W'(valid_q[i]);
            if (!valid_q[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    assign count_o      = occupancy;
    assign disp_ready_o = (occupancy < CNT_W'(RS_DEPTH));
    assign eligible     = valid_q & rdyA_q & rdyB_q;

    // Oldest eligible entry: no other eligible entry is older than it
    always_comb begin
        issFound = 1'b0;
        selIdx   = '0;
        blocked  = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (eligible[j] && older_q[j][i])
                    blocked = 1'b1;
            end
            if (eligible[i] && !blocked && !issFound) begin
                issFound = 1'b1;
                selIdx   = IDX_W'(i);
            end
        end
    end

    assign iss_valid_o    = issFound;
    assign iss_instr_o    = issFound ? instr_q[selIdx]   : '0;
    assign iss_tag_dest_o = issFound ? tagDest_q[selIdx] : '0;
    assign iss_data_a_o   = issFound ? dataA_q[selIdx]   : '0;
    assign iss_data_b_o   = issFound ? dataB_q[selIdx]   : '0;

    assign doIssue = issFound && iss_ready_i;
    assign doDisp  = disp_valid_i && disp_ready_o;

    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        tagDest_d = tagDest_q;
        tagA_d    = tagA_q;
        tagB_d    = tagB_q;
        dataA_d   = dataA_q;
        dataB_d   = dataB_q;
        rdyA_d    = rdyA_q;
        rdyB_d    = rdyB_q;
        older_d   = older_q;
        hitA      = '0;
        hitB      = '0;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i] && !rdyA_q[i]) begin
                hitA = cdbLookup(tagA_q[i]);
                if (hitA[DATA_W]) begin
                    rdyA_d[i]  = 1'b1;
                    dataA_d[i] = hitA[DATA_W-1:0];
                end
            end
            if (valid_q[i] && !rdyB_q[i]) begin
                hitB = cdbLookup(tagB_q[i]);
                if (hitB[DATA_W]) begin
                    rdyB_d[i]  = 1'b1;
                    dataB_d[i] = hitB[DATA_W-1:0];
                end
            end
        end

        if (doIssue)
            valid_d[selIdx] = 1'b0;

        // New entry becomes younger than every other slot; stale bits are rewritten on reuse
        if (doDisp) begin
            hitA = cdbLookup(disp_tag_a_i);
            hitB = cdbLookup(disp_tag_b_i);
            valid_d[freeIdx]   = 1'b1;
            instr_d[freeIdx]   = disp_instr_i;
            tagDest_d[freeIdx] = disp_tag_dest_i;
            tagA_d[freeIdx]    = disp_tag_a_i;
            tagB_d[freeIdx]    = disp_tag_b_i;
            rdyA_d[freeIdx]    = disp_rdy_a_i || hitA[DATA_W];
            rdyB_d[freeIdx]    = disp_rdy_b_i || hitB[DATA_W];
            dataA_d[freeIdx]   = (!disp_rdy_a_i && hitA[DATA_W]) ? hitA[DATA_W-1:0] : disp_data_a_i;
            dataB_d[freeIdx]   = (!disp_rdy_b_i && hitB[DATA_W]) ? hitB[DATA_W-1:0] : disp_data_b_i;
            older_d[freeIdx]   = '0;
            for (int j = 0; j < RS_DEPTH; j++)
                older_d[j][freeIdx] = (IDX_W'(j) != freeIdx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i)
            valid_q <= '0;
        else
            valid_q <= valid_d;
        instr_q   <= instr_d;
        tagDest_q <= tagDest_d;
        tagA_q    <= tagA_d;
        tagB_q    <= tagB_d;
        dataA_q   <= dataA_d;
        dataB_q   <= dataB_d;
        rdyA_q    <= rdyA_d;
        rdyB_q    <= rdyB_d;
        older_q   <= older_d;
    end

endmodule

// File: tb/tb_mult_div_rs_age.sv
// Self-checking bench for mult_div_rs_age: directed scenarios plus random traffic
// compared against a queue-in-dispatch-order reference model.
module tb_mult_div_rs_age;

    logic         clk = 1'b0;
    logic         rst, flush, disp_valid, disp_ready;
    logic [31:0]  disp_instr;
    logic [3:0]   disp_tag_dest, disp_tag_a, disp_tag_b;
    logic [31:0]  disp_data_a, disp_data_b;
    logic         disp_rdy_a, disp_rdy_b;
    logic [3:0]   cdb_valid;
    logic [15:0]  cdb_tag;
    logic [127:0] cdb_data;
    logic         commit_valid;
    logic [3:0]   commit_tag;
    logic [31:0]  commit_data;
    logic         iss_valid, iss_ready;
    logic [31:0]  iss_instr;
    logic [3:0]   iss_tag_dest;
    logic [31:0]  iss_data_a, iss_data_b;
    logic [2:0]   count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  td, ta, tb;
        logic [31:0] da, db;
        logic        ra, rb;
    } ent_t;

    ent_t mq[$];

    always #5 clk = ~clk;

    mult_div_rs_age dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_instr_i(disp_instr), .disp_tag_dest_i(disp_tag_dest),
        .disp_tag_a_i(disp_tag_a), .disp_tag_b_i(disp_tag_b),
        .disp_data_a_i(disp_data_a), .disp_data_b_i(disp_data_b),
        .disp_rdy_a_i(disp_rdy_a), .disp_rdy_b_i(disp_rdy_b),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .commit_valid_i(commit_valid), .commit_tag_i(commit_tag), .commit_data_i(commit_data),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
        .iss_instr_o(iss_instr), .iss_tag_dest_o(iss_tag_dest),
        .iss_data_a_o(iss_data_a), .iss_data_b_o(iss_data_b),
        .count_o(count)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_instr = '0;
        disp_tag_dest = '0; disp_tag_a = '0; disp_tag_b = '0;
        disp_data_a = '0; disp_data_b = '0; disp_rdy_a = 1'b0; disp_rdy_b = 1'b0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        commit_valid = 1'b0; commit_tag = '0; commit_data = '0; iss_ready = 1'b0;
    endtask

    task automatic setDisp(input logic [31:0] instr, input logic [3:0] td,
                           input logic [3:0] ta, input logic [31:0] da, input logic ra,
                           input logic [3:0] tb, input logic [31:0] db, input logic rb);
        disp_valid = 1'b1; disp_instr = instr; disp_tag_dest = td;
        disp_tag_a = ta; disp_data_a = da; disp_rdy_a = ra;
        disp_tag_b = tb; disp_data_b = db; disp_rdy_b = rb;
    endtask

    task automatic setCdb(input int p, input logic [3:0] tag, input logic [31:0] data);
        cdb_valid[p]        = 1'b1;
        cdb_tag[p*4 +: 4]   = tag;
        cdb_data[p*32 +: 32] = data;
    endtask

    // Forwarded value for a tag this cycle: first matching CDB port, else commit
    function automatic logic [32:0] mlookup(input logic [3:0] tag);
        for (int p = 0; p < 4; p++)
            if (cdb_valid[p] && cdb_tag[p*4 +: 4] == tag)
                return {1'b1, cdb_data[p*32 +: 32]};
        if (commit_valid && commit_tag == tag)
            return {1'b1, commit_data};
        return 33'd0;
    endfunction

    function automatic int oldestReady();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].ra && mq[i].rb)
                return i;
        return -1;
    endfunction

    task automatic checkOutput();
        int s;
        s = oldestReady();
        checkVal("count", 32'(count), 32'(mq.size()));
        checkVal("disp_ready", 32'(disp_ready), 32'(mq.size() < 4));
        checkVal("iss_valid", 32'(iss_valid), 32'(s >= 0));
        checkVal("iss_instr", iss_instr, (s >= 0) ? mq[s].instr : 32'd0);
        checkVal("iss_tag_dest", 32'(iss_tag_dest), (s >= 0) ? 32'(mq[s].td) : 32'd0);
        checkVal("iss_data_a", iss_data_a, (s >= 0) ? mq[s].da : 32'd0);
        checkVal("iss_data_b", iss_data_b, (s >= 0) ? mq[s].db : 32'd0);
    endtask

    task automatic modelUpdate();
        ent_t e;
        logic [32:0] r;
        int sz, s;
        if (rst || flush) begin
            mq.delete();
            return;
        end
        sz = mq.size();
        s  = oldestReady();
        if (s >= 0 && iss_ready)
            mq.delete(s);
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (!e.ra) begin
                r = mlookup(e.ta);
                if (r[32]) begin e.ra = 1'b1; e.da = r[31:0]; end
            end
            if (!e.rb) begin
                r = mlookup(e.tb);
                if (r[32]) begin e.rb = 1'b1; e.db = r[31:0]; end
            end
            mq[i] = e;
        end
        if (disp_valid && sz < 4) begin
            e.instr = disp_instr; e.td = disp_tag_dest;
            e.ta = disp_tag_a; e.da = disp_data_a; e.ra = disp_rdy_a;
            e.tb = disp_tag_b; e.db = disp_data_b; e.rb = disp_rdy_b;
            if (!e.ra) begin
                r = mlookup(e.ta);
                if (r[32]) begin e.ra = 1'b1; e.da = r[31:0]; end
            end
            if (!e.rb) begin
                r = mlookup(e.tb);
                if (r[32]) begin e.rb = 1'b1; e.db = r[31:0]; end
            end
            mq.push_back(e);
        end
    endtask

    // One clock: check registered outputs, advance the model, then clear the inputs
    task automatic applyStimulus();
        checkOutput();
        modelUpdate();
        @(posedge clk);
        @(negedge clk);
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus();
        checkVal("reset_count", 32'(count), 32'd0);
        checkVal("reset_disp_ready", 32'(disp_ready), 32'd1);
        checkVal("reset_iss_valid", 32'(iss_valid), 32'd0);

        for (int k = 0; k < 5; k++) begin
            setDisp(32'h1000 + k, 4'(k), 4'(8 + k), 32'd0, 1'b0, 4'(12), 32'd0, 1'b0);
            applyStimulus();
        end
        checkVal("fill_count", 32'(count), 32'd4);
        checkVal("fill_disp_ready", 32'(disp_ready), 32'd0);
        checkVal("fill_iss_valid", 32'(iss_valid), 32'd0);

        flush = 1'b1;
        setDisp(32'h2000, 4'd1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1);
        applyStimulus();
        checkVal("flush_full_count", 32'(count), 32'd0);
        checkVal("flush_full_iss_valid", 32'(iss_valid), 32'd0);

        setDisp(32'hA, 4'd1, 4'd3, 32'd0, 1'b0, 4'd0, 32'h11, 1'b1);
        applyStimulus();
        setDisp(32'hB, 4'd2, 4'd5, 32'd0, 1'b0, 4'd0, 32'h22, 1'b1);
        applyStimulus();
        setCdb(2, 4'd5, 32'hB0B0_0005);
        applyStimulus();
        checkVal("age_b_first", 32'(iss_tag_dest), 32'd2);
        setCdb(0, 4'd3, 32'hA0A0_0003);
        iss_ready = 1'b1;
        applyStimulus();
        checkVal("age_a_next", 32'(iss_tag_dest), 32'd1);
        checkVal("age_a_data", iss_data_a, 32'hA0A0_0003);
        iss_ready = 1'b1;
        applyStimulus();
        checkVal("age_empty", 32'(iss_valid), 32'd0);

        setDisp(32'hC1, 4'd4, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2, 1'b1);
        applyStimulus();
        setDisp(32'hC2, 4'd6, 4'd0, 32'h3, 1'b1, 4'd0, 32'h4, 1'b1);
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            checkVal("oldest_hold", 32'(iss_tag_dest), 32'd4);
            applyStimulus();
        end
        iss_ready = 1'b1;
        checkVal("oldest_issue_a", 32'(iss_tag_dest), 32'd4);
        applyStimulus();
        iss_ready = 1'b1;
        checkVal("oldest_issue_b", 32'(iss_tag_dest), 32'd6);
        applyStimulus();

        setDisp(32'hD0, 4'd9, 4'd7, 32'd0, 1'b0, 4'd2, 32'h55, 1'b1);
        setCdb(1, 4'd7, 32'h0000_DEAD);
        setCdb(3, 4'd7, 32'h0000_BEEF);
        commit_valid = 1'b1; commit_tag = 4'd7; commit_data = 32'h1234;
        applyStimulus();
        checkVal("bypass_valid", 32'(iss_valid), 32'd1);
        checkVal("bypass_data_a", iss_data_a, 32'h0000_DEAD);
        iss_ready = 1'b1;
        applyStimulus();

        for (int k = 0; k < 4; k++) begin
            setDisp(32'hE0 + k, 4'(10 + k), 4'd0, 32'(k), 1'b1, 4'd0, 32'(k), 1'b1);
            applyStimulus();
        end
        checkVal("full_count", 32'(count), 32'd4);
        iss_ready = 1'b1;
        setDisp(32'hEF, 4'd15, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9, 1'b1);
        applyStimulus();
        checkVal("full_issue_count", 32'(count), 32'd3);
        checkVal("full_issue_ready", 32'(disp_ready), 32'd1);

        flush = 1'b1;
        iss_ready = 1'b1;
        setDisp(32'hF0, 4'd8, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1);
        applyStimulus();
        checkVal("flush_count", 32'(count), 32'd0);
        checkVal("flush_iss_valid", 32'(iss_valid), 32'd0);
        applyStimulus();
        checkVal("flush_nothing_stored", 32'(count), 32'd0);

        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0)
                setDisp($urandom, 4'($urandom), 4'($urandom), $urandom, 1'($urandom),
                        4'($urandom), $urandom, 1'($urandom));
            for (int p = 0; p < 4; p++)
                if ($urandom_range(0, 2) == 0)
                    setCdb(p, 4'($urandom), $urandom);
            commit_valid = ($urandom_range(0, 3) == 0);
            commit_tag   = 4'($urandom);
            commit_data  = $urandom;
            iss_ready    = 1'($urandom);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_rs_age.md
MULT_DIV_RS_AGE -- requirements
Module: mult_div_rs_age

Interface
REQ-001 Parameter RS_DEPTH, default 4: number of station entries, power of two, >= 2.
REQ-002 Parameter ROB_DEPTH, default 16: ROB tag space; TAG_W = $clog2(ROB_DEPTH).
REQ-003 Parameter NUM_CDB, default 4: number of CDB broadcast ports.
REQ-004 Parameter DATA_W, default 32: operand and result width.
REQ-005 Port clk, input, 1: clock. Reset rst is synchronous and active-high; the clock is clk.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port flush, input, 1: mispredict flush; empties the station.
REQ-008 Port disp_valid / disp_ready, input / output, 1 / 1: dispatch handshake.
REQ-009 Port disp_instr, input, 32: instruction word.
REQ-010 Port disp_tag_dest, input, TAG_W: destination ROB tag.
REQ-011 Ports disp_tag_a / disp_tag_b, input, TAG_W: source ROB tags.
REQ-012 Ports disp_data_a / disp_data_b, input, DATA_W: source data.
REQ-013 Ports disp_rdy_a / disp_rdy_b, input, 1: source data valid.
REQ-014 Ports cdb_valid / cdb_tag / cdb_data, input, NUM_CDB x (1 / TAG_W / DATA_W): broadcast buses.
REQ-015 Ports commit_valid / commit_tag / commit_data, input, 1 / TAG_W / DATA_W: ROB commit forward.
REQ-016 Port iss_valid / iss_ready, output / input, 1 / 1: issue handshake to mult/div unit.
REQ-017 Ports iss_instr / iss_tag_dest / iss_data_a / iss_data_b, output, 32 / TAG_W / DATA_W / DATA_W: issued entry payload.
REQ-018 Port count, output, $clog2(RS_DEPTH)+1: occupied entries.

Function
REQ-019 Each entry SHALL hold valid, instr, tag_dest, per-source {tag, data, rdy}, and dispatch age.
REQ-020 disp_ready SHALL equal (count < RS_DEPTH) from registered state only; no combinational path from iss_ready or disp_valid.
REQ-021 On disp_valid && disp_ready, payload SHALL be written to the lowest-index free entry at the clock edge.
REQ-022 Dispatch-cycle bypass: if a source has rdy=0 and its tag matches any valid CDB port or commit_tag (commit_valid) in the same cycle, the entry SHALL store that data with rdy=1.
REQ-023 Wakeup: each cycle, every valid entry with a not-ready source whose tag matches a valid CDB port or commit SHALL capture that data and set rdy=1 at the edge.
REQ-024 Multiple matching CDB ports on one source SHALL resolve to the lowest port index; a CDB match SHALL take priority over a commit match.
REQ-025 An entry is eligible when valid, rdy_a and rdy_b are registered high; data captured in cycle t becomes eligible in cycle t+1.
REQ-026 iss_valid SHALL be high iff at least one entry is eligible; the selected entry SHALL be the oldest eligible entry in dispatch order, not index order.
REQ-027 iss_* payload SHALL be driven from the selected entry, combinationally from registered state; it SHALL be zero when iss_valid=0.
REQ-028 On iss_valid && iss_ready the selected entry SHALL be invalidated at the edge; at most one issue per cycle.
REQ-029 While iss_valid && !iss_ready, selection SHALL stay stable unless an older entry becomes eligible; the payload shall never be partially updated.
REQ-030 Simultaneous dispatch and issue SHALL be legal; count changes by +1, -1 or 0 accordingly.
REQ-031 Age order SHALL be maintained across arbitrary free/reuse patterns with no wrap-around aliasing.
REQ-032 Entry fields SHALL not be modified by wakeup once rdy is set.

Reset
REQ-033 On rst or flush all entries SHALL be invalid and count=0 at the next edge; disp_ready=1 and iss_valid=0 afterwards; a dispatch or issue in the same cycle SHALL be discarded.
REQ-034 rst/flush mid-occupancy SHALL discard all entries regardless of readiness; no issue occurs in the reset cycle.

Verification
REQ-035 Fill: 4 dispatches, sources not ready, iss_ready=0 -> count=4, disp_ready=0, iss_valid=0; fifth disp_valid ignored.
REQ-036 Age order: dispatch A(tag 3) then B(tag 5), both waiting; CDB port 2 wakes B first, then CDB port 0 wakes A -> B issues first, then A is next.
REQ-037 Oldest-first: A, B dispatched ready, iss_ready=0 for 3 cycles -> iss_tag_dest stays at A's tag; iss_ready=1 -> A issues, then B.
REQ-038 Bypass: dispatch src_a tag 7 rdy=0 while cdb_valid[1]=1, cdb_tag[1]=7, data 0xDEAD -> next cycle iss_valid=1, iss_data_a=0xDEAD.
REQ-039 Full with issue: count=4, iss_ready=1 -> count=3 next cycle, disp_ready=1; no dispatch accepted in the full cycle.
REQ-040 Flush: 3 entries, flush plus disp_valid in the same cycle -> count=0, iss_valid=0, nothing stored.
